// File: rtl/simon_pkg.sv
// Shared definitions for the Simon Says round sequencer: state encoding,
// debug codes shown on the status pins, and the round index width.
package simon_pkg;

  localparam int ROUND_W = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GEN   = 3'd1,
    S_DISP  = 3'd2,
    S_WAIT  = 3'd3,
    S_CHECK = 3'd4,
    S_WIN   = 3'd5,
    S_LOSE  = 3'd6
  } state_t;

  localparam logic [1:0] DBG_OTHER = 2'b00;
  localparam logic [1:0] DBG_DISP  = 2'b01;
  localparam logic [1:0] DBG_WAIT  = 2'b10;
  localparam logic [1:0] DBG_CHECK = 2'b11;

  // Only the three player-visible phases get their own code; everything else reads as 00.
  function automatic logic [1:0] dbg_code(input state_t s);
    case (s)
      S_DISP:  dbg_code = DBG_DISP;
      S_WAIT:  dbg_code = DBG_WAIT;
      S_CHECK: dbg_code = DBG_CHECK;
      default: dbg_code = DBG_OTHER;
    endcase
  endfunction

endpackage

// File: rtl/simon_timeout_timer.sv
// Player input timeout: counts cycles while enabled and flags the last allowed
// cycle so the sequencer can force a loss on that same edge.
module simon_timeout_timer #(
  parameter int unsigned         TO_W           = 24,
  parameter logic [TO_W-1:0]     TIMEOUT_CYCLES = 24'd1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [TO_W-1:0] LAST = TIMEOUT_CYCLES - TO_W'(1);

  logic [TO_W-1:0] r_cnt;

  // Saturates at all-ones so a stalled enable can never wrap back to a live value.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + TO_W'(1);
    end
  end

  assign o_expire = i_en && (r_cnt == LAST);

endmodule

// File: rtl/simon_round_sequencer.sv
// Central Simon Says game FSM: sequences generate/display/wait/check phases via
// go/done pulse handshakes, owns the round counter and reports win/lose.
module simon_round_sequencer
  import simon_pkg::*;
#(
  parameter int unsigned     MAX_ROUNDS     = 16,
  parameter int unsigned     TO_W           = 24,
  parameter logic [TO_W-1:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic               i_gen_done,
  input  logic               i_disp_done,
  input  logic               i_wait_done,
  input  logic               i_check_done,
  input  logic               i_check_ok,
  output logic               o_gen_go,
  output logic               o_disp_go,
  output logic               o_wait_go,
  output logic               o_check_go,
  output logic               o_phase_clr,
  output logic [ROUND_W-1:0] o_round,
  output logic [1:0]         o_state_dbg,
  output logic               o_game_win,
  output logic               o_game_lose
);

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(MAX_ROUNDS - 1);

  state_t               r_state, w_next_state;
  logic [ROUND_W-1:0]   r_round, w_next_round;
  logic                 r_start_q;
  logic                 r_gen_go, r_disp_go, r_wait_go, r_check_go, r_phase_clr;
  logic [1:0]           r_state_dbg;
  logic                 r_win, r_lose;
  logic                 w_gen_go, w_disp_go, w_wait_go, w_check_go, w_phase_clr;
  logic                 w_start_rise, w_expire;

  assign w_start_rise = i_start & ~r_start_q;

  simon_timeout_timer #(
    .TO_W          (TO_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (r_state != S_WAIT),
    .i_en    (r_state == S_WAIT),
    .o_expire(w_expire)
  );

  always_comb begin
    w_next_state = r_state;
    w_next_round = r_round;
    w_gen_go     = 1'b0;
    w_disp_go    = 1'b0;
    w_wait_go    = 1'b0;
    w_check_go   = 1'b0;
    w_phase_clr  = 1'b0;
    case (r_state)
      S_IDLE, S_WIN, S_LOSE: begin
        if (w_start_rise) begin
          w_next_state = S_GEN;
          w_next_round = '0;
          w_gen_go     = 1'b1;
          w_phase_clr  = 1'b1;
        end
      end
      S_GEN: begin
        if (i_gen_done) begin
          w_next_state = S_DISP;
          w_disp_go    = 1'b1;
        end
      end
      S_DISP: begin
        if (i_disp_done) begin
          w_next_state = S_WAIT;
          w_wait_go    = 1'b1;
        end
      end
      S_WAIT: begin
        // A completed entry on the last allowed cycle still counts.
        if (i_wait_done) begin
          w_next_state = S_CHECK;
          w_check_go   = 1'b1;
        end else if (w_expire) begin
          w_next_state = S_LOSE;
        end
      end
      S_CHECK: begin
        if (i_check_done) begin
          if (!i_check_ok) begin
            w_next_state = S_LOSE;
          end else if (r_round == LAST_ROUND) begin
            w_next_state = S_WIN;
          end else begin
            w_next_state = S_DISP;
            w_next_round = r_round + ROUND_W'(1);
            w_disp_go    = 1'b1;
            w_phase_clr  = 1'b1;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Status outputs decode the next state so they line up with the go pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_round     <= '0;
      r_start_q   <= 1'b0;
      r_gen_go    <= 1'b0;
      r_disp_go   <= 1'b0;
      r_wait_go   <= 1'b0;
      r_check_go  <= 1'b0;
      r_phase_clr <= 1'b0;
      r_state_dbg <= DBG_OTHER;
      r_win       <= 1'b0;
      r_lose      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_round     <= w_next_round;
      r_start_q   <= i_start;
      r_gen_go    <= w_gen_go;
      r_disp_go   <= w_disp_go;
      r_wait_go   <= w_wait_go;
      r_check_go  <= w_check_go;
      r_phase_clr <= w_phase_clr;
      r_state_dbg <= dbg_code(w_next_state);
      r_win       <= (w_next_state == S_WIN);
      r_lose      <= (w_next_state == S_LOSE);
    end
  end

  assign o_gen_go    = r_gen_go;
  assign o_disp_go   = r_disp_go;
  assign o_wait_go   = r_wait_go;
  assign o_check_go  = r_check_go;
  assign o_phase_clr = r_phase_clr;
  assign o_round     = r_round;
  assign o_state_dbg = r_state_dbg;
  assign o_game_win  = r_win;
  assign o_game_lose = r_lose;

endmodule

// File: tb/tb_simon_round_sequencer.sv
// Scoreboard bench for simon_round_sequencer: a game-level reference model predicts
// every output event (pulse or status change) with the cycle it must appear in.
module tb_simon_round_sequencer;

  localparam int MAXR = 16;
  localparam int TMO  = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, gen_done = 1'b0, disp_done = 1'b0, wait_done = 1'b0;
  logic       check_done = 1'b0, check_ok = 1'b0;
  logic       gen_go, disp_go, wait_go, check_go, phase_clr, game_win, game_lose;
  logic [3:0] round;
  logic [1:0] state_dbg;

  simon_round_sequencer #(
    .MAX_ROUNDS    (MAXR),
    .TO_W          (24),
    .TIMEOUT_CYCLES(24'd20)
  ) dut (
    .clk(clk), .reset(reset), .i_start(start),
    .i_gen_done(gen_done), .i_disp_done(disp_done), .i_wait_done(wait_done),
    .i_check_done(check_done), .i_check_ok(check_ok),
    .o_gen_go(gen_go), .o_disp_go(disp_go), .o_wait_go(wait_go), .o_check_go(check_go),
    .o_phase_clr(phase_clr), .o_round(round), .o_state_dbg(state_dbg),
    .o_game_win(game_win), .o_game_lose(game_lose)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       gen, disp, wt, chk, clr;
    logic [3:0] rnd;
    logic [1:0] dbg;
    logic       win, lose;
  } obs_t;

  typedef struct {
    int   stamp;
    obs_t o;
  } exp_t;

  exp_t q[$];
  int   cyc_n = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   mon_en = 0;
  obs_t prev_obs = '0;
  obs_t cur_obs;
  exp_t e_pop;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // ---------------- reference model (game-level phases) ----------------
  typedef enum int {P_IDLE, P_GEN, P_SHOW, P_PLAYER, P_JUDGE, P_WON, P_LOST} phase_t;
  phase_t m_ph = P_IDLE;
  int     m_round = 0;
  int     m_ticks = 0;
  bit     m_prev_start = 0;
  obs_t   m_last = '0;
  bit     s_lvl = 0;

  task automatic model(input bit rst, st, gd, dd, wd, cd, ok);
    obs_t n;
    exp_t e;
    bit   rise;
    n = '0;
    if (rst) begin
      m_ph = P_IDLE; m_round = 0; m_ticks = 0; m_prev_start = 0;
    end else begin
      rise = st && !m_prev_start;
      m_prev_start = st;
      case (m_ph)
        P_IDLE, P_WON, P_LOST:
          if (rise) begin m_ph = P_GEN; m_round = 0; n.gen = 1; n.clr = 1; end
        P_GEN:  if (gd) begin m_ph = P_SHOW; n.disp = 1; end
        P_SHOW: if (dd) begin m_ph = P_PLAYER; n.wt = 1; m_ticks = 0; end
        P_PLAYER: begin
          if (wd) begin m_ph = P_JUDGE; n.chk = 1; end
          else begin
            m_ticks++;
            if (m_ticks == TMO) m_ph = P_LOST;
          end
        end
        P_JUDGE: if (cd) begin
          if (!ok) m_ph = P_LOST;
          else if (m_round == MAXR - 1) m_ph = P_WON;
          else begin m_ph = P_SHOW; m_round++; n.disp = 1; n.clr = 1; end
        end
        default: m_ph = P_IDLE;
      endcase
    end
    n.rnd  = 4'(m_round);
    n.dbg  = (m_ph == P_SHOW) ? 2'd1 : (m_ph == P_PLAYER) ? 2'd2 : (m_ph == P_JUDGE) ? 2'd3 : 2'd0;
    n.win  = (m_ph == P_WON);
    n.lose = (m_ph == P_LOST);
    if (n.gen || n.disp || n.wt || n.chk || n.clr || n.rnd != m_last.rnd ||
        n.dbg != m_last.dbg || n.win != m_last.win || n.lose != m_last.lose) begin
      e.stamp = cyc_n + 1;
      e.o = n;
      q.push_back(e);
    end
    m_last = n;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      cur_obs = '{gen: gen_go, disp: disp_go, wt: wait_go, chk: check_go, clr: phase_clr,
                  rnd: round, dbg: state_dbg, win: game_win, lose: game_lose};
      if (cur_obs.gen || cur_obs.disp || cur_obs.wt || cur_obs.chk || cur_obs.clr ||
          cur_obs.rnd != prev_obs.rnd || cur_obs.dbg != prev_obs.dbg ||
          cur_obs.win != prev_obs.win || cur_obs.lose != prev_obs.lose) begin
        n_checks++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_event cyc=%0d got=%b required=none", cyc_n, cur_obs);
        end else begin
          e_pop = q.pop_front();
          if (e_pop.stamp != cyc_n || e_pop.o != cur_obs)
            $display("FAIL event cyc=%0d got=%b required=%b@cyc%0d", cyc_n, cur_obs, e_pop.o, e_pop.stamp);
          else
            n_pass++;
        end
      end
      prev_obs = cur_obs;
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at posedge+1: drives one cycle of inputs, returns just after they are consumed.
  task automatic step(input bit rst, gd, dd, wd, cd, ok);
    reset = rst; start = s_lvl; gen_done = gd; disp_done = dd; wait_done = wd;
    check_done = cd; check_ok = ok;
    model(rst, s_lvl, gd, dd, wd, cd, ok);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic press();
    s_lvl = 1; step(0, 0, 0, 0, 0, 0);
    s_lvl = 0; step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic advance(input bit ok);
    idle($urandom_range(0, 3));
    case (m_ph)
      P_GEN:    step(0, 1, 0, 0, 0, 0);
      P_SHOW:   step(0, 0, 1, 0, 0, 0);
      P_PLAYER: step(0, 0, 0, 1, 0, 0);
      P_JUDGE:  step(0, 0, 0, 0, 1, ok);
      default:  press();
    endcase
  endtask

  task automatic chk(input string nm, input int got, input int req);
    n_checks++;
    if (got == req) n_pass++;
    else $display("FAIL %s got=%0d required=%0d", nm, got, req);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gen_go"}, gen_go, 0);
    chk({tag, "_disp_go"}, disp_go, 0);
    chk({tag, "_wait_go"}, wait_go, 0);
    chk({tag, "_check_go"}, check_go, 0);
    chk({tag, "_phase_clr"}, phase_clr, 0);
    chk({tag, "_round"}, round, 0);
    chk({tag, "_dbg"}, state_dbg, 0);
    chk({tag, "_win"}, game_win, 0);
    chk({tag, "_lose"}, game_lose, 0);
  endtask

  bit r_rst, r_gd, r_dd, r_wd, r_cd, r_ok;
  int guard;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0, 0);
    mon_en = 1;
    step(1, 0, 0, 0, 0, 0);
    chk_reset_vals("reset");

    // First start: gen_go one cycle later, then gen_done -> DISP.
    s_lvl = 1; step(0, 0, 0, 0, 0, 0);
    chk("start_gen_go", gen_go, 1);
    chk("start_dbg", state_dbg, 0);
    s_lvl = 0; step(0, 1, 0, 0, 0, 0);
    chk("gen_done_disp_go", disp_go, 1);
    chk("gen_done_dbg", state_dbg, 1);

    // Play a full winning game.
    guard = 0;
    while (m_ph != P_WON && guard < 500) begin advance(1); guard++; end
    chk("win_flag", game_win, 1);
    chk("win_round", round, MAXR - 1);
    idle(3);
    press();
    chk("restart_win_drop", game_win, 0);
    chk("restart_round", round, 0);

    // Lose on a mismatch in round 2.
    guard = 0;
    while (!(m_ph == P_JUDGE && m_round == 2) && guard < 200) begin advance(1); guard++; end
    step(0, 0, 0, 0, 1, 0);
    chk("mismatch_lose", game_lose, 1);
    chk("mismatch_round", round, 2);
    chk("mismatch_dbg", state_dbg, 0);

    // Timeout: exactly TMO idle cycles in WAIT.
    press();
    guard = 0;
    while (m_ph != P_PLAYER && guard < 50) begin advance(1); guard++; end
    idle(TMO - 1);
    chk("tmo_still_wait", state_dbg, 2);
    idle(1);
    chk("tmo_lose", game_lose, 1);

    // wait_done on the expiry cycle wins over the timeout.
    press();
    guard = 0;
    while (m_ph != P_PLAYER && guard < 50) begin advance(1); guard++; end
    idle(TMO - 1);
    step(0, 0, 0, 1, 0, 0);
    chk("tmo_edge_check", state_dbg, 3);

    // Stray inputs in non-matching states.
    step(0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1);
    chk("to_disp_round", round, 1);
    press();
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("stray_disp_dbg", state_dbg, 1);
    chk("stray_disp_round", round, 1);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("stray_wait_dbg", state_dbg, 2);

    // Reset in CHECK together with check_done.
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 1, 1);
    chk_reset_vals("midreset");
    idle(2);

    // Randomized play.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) s_lvl = ~s_lvl;
      r_rst = ($urandom_range(0, 499) == 0);
      r_gd  = $urandom_range(0, 99) < ((m_ph == P_GEN) ? 40 : 3);
      r_dd  = $urandom_range(0, 99) < ((m_ph == P_SHOW) ? 40 : 3);
      r_wd  = $urandom_range(0, 99) < ((m_ph == P_PLAYER) ? 30 : 3);
      r_cd  = $urandom_range(0, 99) < ((m_ph == P_JUDGE) ? 40 : 3);
      r_ok  = $urandom_range(0, 99) < 93;
      step(r_rst, r_gd, r_dd, r_wd, r_cd, r_ok);
    end
    idle(4);
    chk("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
